// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer.
// Optional pause input is enabled by defining TIMER_PAUSE_EN.
package timer_pkg;

   // Top-level timer states; busy is asserted only in RUN.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } timer_state_e;

   // Mode encoding sampled on start.
   localparam logic MODE_ONESHOT  = 1'b0;
   localparam logic MODE_PERIODIC = 1'b1;

   // Default widths for the main counter and the prescaler reload value.
   localparam int unsigned TIMER_WIDTH_DEF = 16;
   localparam int unsigned PRESC_W_DEF     = 8;

endpackage : timer_pkg

// File: rtl/timer_prescaler.sv
// Prescaler for the countdown timer: emits a tick every presc_val+1 enabled
// clocks. The reload strobe loads both the running count and the captured
// reload value, and suppresses the tick on that edge.
module timer_prescaler
   import timer_pkg::*;
#(
   parameter int unsigned PRESC_W = PRESC_W_DEF
) (
   input  logic               clk,
   input  logic               clr_b,
   input  logic               enable,
   input  logic               reload,
   input  logic [PRESC_W-1:0] presc_val,
   output logic               tick
);

   logic [PRESC_W-1:0] cnt_q, cnt_d;
   logic [PRESC_W-1:0] rld_q, rld_d;

   // Next-state: reload wins, otherwise count down and wrap to the captured value.
   always_comb begin
      cnt_d = cnt_q;
      rld_d = rld_q;
      tick  = 1'b0;
      if (reload) begin
         cnt_d = presc_val;
         rld_d = presc_val;
      end else if (enable) begin
         if (cnt_q == '0) begin
            tick  = 1'b1;
            cnt_d = rld_q;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   // Prescaler storage, cleared asynchronously.
   always_ff @(posedge clk or negedge clr_b) begin
      if (!clr_b) begin
         cnt_q <= '0;
         rld_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         rld_q <= rld_d;
      end
   end

endmodule : timer_prescaler

// File: rtl/countdown_timer.sv
// Programmable down-counting timer with prescaler, one-shot and periodic
// modes, a registered one-cycle expiry pulse and a sticky interrupt flag.
// Define TIMER_PAUSE_EN to add the pause input, which freezes both counters
// while running.
module countdown_timer
   import timer_pkg::*;
#(
   parameter int unsigned WIDTH   = TIMER_WIDTH_DEF,
   parameter int unsigned PRESC_W = PRESC_W_DEF
) (
   input  logic               clk,
   input  logic               clr_b,
   input  logic [WIDTH-1:0]   load_val,
   input  logic [PRESC_W-1:0] presc_val,
   input  logic               mode,
   input  logic               start,
   input  logic               stop,
   input  logic               irq_ack,
`ifdef TIMER_PAUSE_EN
   input  logic               pause,
`endif
   output logic [WIDTH-1:0]   count,
   output logic               busy,
   output logic               expired,
   output logic               irq
);

   timer_state_e     state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] load_q, load_d;
   logic             mode_q, mode_d;
   logic             expired_q, expired_d;
   logic             irq_q, irq_d;

   logic             start_ok;
   logic             run_en;
   logic             presc_reload;
   logic             tick;

   // A start is only honoured with a non-zero load value and no coincident stop.
   assign start_ok = start && !stop && (load_val != '0);

`ifdef TIMER_PAUSE_EN
   assign run_en = (state_q == RUN) && !pause;
`else
   assign run_en = (state_q == RUN);
`endif

   timer_prescaler #(
      .PRESC_W (PRESC_W)
   ) u_presc (
      .clk       (clk),
      .clr_b     (clr_b),
      .enable    (run_en),
      .reload    (presc_reload),
      .presc_val (presc_val),
      .tick      (tick)
   );

   // FSM next-state, main counter and irq update.
   always_comb begin
      state_d      = state_q;
      count_d      = count_q;
      load_d       = load_q;
      mode_d       = mode_q;
      expired_d    = 1'b0;
      irq_d        = irq_q && !irq_ack;
      presc_reload = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            if (start_ok) begin
               state_d      = RUN;
               count_d      = load_val;
               load_d       = load_val;
               mode_d       = mode;
               presc_reload = 1'b1;
            end
         end

         RUN: begin
            if (stop) begin
               // Abort: count freezes where it is.
               state_d = IDLE;
            end else if (start_ok) begin
               // Restart takes precedence over a coincident tick.
               count_d      = load_val;
               load_d       = load_val;
               mode_d       = mode;
               presc_reload = 1'b1;
            end else if (run_en && tick) begin
               if (count_q > WIDTH'(1)) begin
                  count_d = count_q - WIDTH'(1);
               end else if (count_q == WIDTH'(1)) begin
                  expired_d = 1'b1;
                  irq_d     = 1'b1;
                  if (mode_q == MODE_PERIODIC) begin
                     count_d = load_q;
                  end else begin
                     count_d = '0;
                     state_d = DONE;
                  end
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Timer state registers, cleared asynchronously.
   always_ff @(posedge clk or negedge clr_b) begin
      if (!clr_b) begin
         state_q   <= IDLE;
         count_q   <= '0;
         load_q    <= '0;
         mode_q    <= MODE_ONESHOT;
         expired_q <= 1'b0;
         irq_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         load_q    <= load_d;
         mode_q    <= mode_d;
         expired_q <= expired_d;
         irq_q     <= irq_d;
      end
   end

   assign count   = count_q;
   assign busy    = (state_q == RUN);
   assign expired = expired_q;
   assign irq     = irq_q;

endmodule : countdown_timer

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer.
// Exercises the pause input as well when TIMER_PAUSE_EN is defined.
module tb_countdown_timer;

   logic        clk = 1'b0;
   logic        clr_b;
   logic [15:0] load_val;
   logic [7:0]  presc_val;
   logic        mode;
   logic        start;
   logic        stop;
   logic        irq_ack;
   logic        pause;
   logic [15:0] count;
   logic        busy;
   logic        expired;
   logic        irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   countdown_timer #(
      .WIDTH   (16),
      .PRESC_W (8)
   ) dut (
      .clk       (clk),
      .clr_b     (clr_b),
      .load_val  (load_val),
      .presc_val (presc_val),
      .mode      (mode),
      .start     (start),
      .stop      (stop),
      .irq_ack   (irq_ack),
`ifdef TIMER_PAUSE_EN
      .pause     (pause),
`endif
      .count     (count),
      .busy      (busy),
      .expired   (expired),
      .irq       (irq)
   );

   // Advance n rising edges and settle 1 time unit after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Single-cycle start strobe; returns just after the sampling edge.
   task automatic do_start(input logic [15:0] l, input logic [7:0] p, input logic m);
      load_val  = l;
      presc_val = p;
      mode      = m;
      start     = 1'b1;
      step(1);
      start     = 1'b0;
   endtask

   task automatic test_reset();
      logic [18:0] exp;
      clr_b = 1'b0; load_val = '0; presc_val = '0; mode = 1'b0;
      start = 1'b0; stop = 1'b0; irq_ack = 1'b0; pause = 1'b0;
      #2;
      exp = 19'h0;
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL reset_initial got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      step(2);
      clr_b = 1'b1;
      step(1);
      do_start(16'd5, 8'd3, 1'b0);
      step(1);
      exp = {1'b1, 1'b0, 1'b0, 16'd5};
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL reset_precount got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      // Assert reset between edges: outputs must clear without a clock edge.
      #3 clr_b = 1'b0;
      #1;
      exp = 19'h0;
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL reset_async got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      #2 clr_b = 1'b1;
      step(1);
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL reset_idle_after got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
   endtask

   task automatic test_oneshot();
      logic [18:0] exp;
      do_start(16'd3, 8'd0, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         step(1);
         if (i < 3) exp = {1'b1, 1'b0, 1'b0, 16'(3 - i)};
         else       exp = {1'b0, 1'b1, 1'b1, 16'd0};
         checks++;
         if ({busy, expired, irq, count} !== exp) begin
            errors++;
            $display("FAIL oneshot_edge%0d got=%h exp=%h", i, {busy, expired, irq, count}, exp);
         end
      end
      step(1);
      exp = {1'b0, 1'b0, 1'b1, 16'd0};
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL oneshot_pulse_end got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      irq_ack = 1'b1;
      step(1);
      irq_ack = 1'b0;
      exp = 19'h0;
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL oneshot_ack got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
   endtask

   task automatic test_periodic();
      logic [18:0] exp;
      logic [15:0] c;
      do_start(16'd2, 8'd3, 1'b1);
      // Ticks every 4 edges; expiry every 8 edges.
      for (int e = 1; e <= 32; e++) begin
         step(1);
         c   = (((e / 4) % 2) == 1) ? 16'd1 : 16'd2;
         exp = {1'b1, (e % 8) == 0, e >= 8, c};
         checks++;
         if ({busy, expired, irq, count} !== exp) begin
            errors++;
            $display("FAIL periodic_edge%0d got=%h exp=%h", e, {busy, expired, irq, count}, exp);
         end
      end
      stop = 1'b1; irq_ack = 1'b1;
      step(1);
      stop = 1'b0; irq_ack = 1'b0;
      exp = {1'b0, 1'b0, 1'b0, 16'd2};
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL periodic_stop got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
   endtask

   task automatic test_stop_restart();
      logic [18:0] exp;
      logic        seen;
      do_start(16'd10, 8'd0, 1'b0);
      step(4);
      exp = {1'b1, 1'b0, 1'b0, 16'd6};
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL stop_pre got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      exp = {1'b0, 1'b0, 1'b0, 16'd6};
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL stop_hold got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      seen = 1'b0;
      repeat (12) begin
         step(1);
         seen = seen | expired | busy;
      end
      checks++;
      if ({seen, irq, count} !== {1'b0, 1'b0, 16'd6}) begin
         errors++;
         $display("FAIL stop_quiet got=%h exp=%h", {seen, irq, count}, {1'b0, 1'b0, 16'd6});
      end
      // start and stop together while idle: stop wins.
      load_val = 16'd7; start = 1'b1; stop = 1'b1;
      step(1);
      start = 1'b0; stop = 1'b0;
      step(1);
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL start_stop_same got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      // Restart while running reloads from the new load value.
      do_start(16'd10, 8'd0, 1'b0);
      step(3);
      do_start(16'd9, 8'd0, 1'b0);
      exp = {1'b1, 1'b0, 1'b0, 16'd9};
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL restart_reload got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      // Restart on the edge that would have expired: no expiry.
      do_start(16'd2, 8'd0, 1'b0);
      step(1);
      do_start(16'd5, 8'd0, 1'b0);
      exp = {1'b1, 1'b0, 1'b0, 16'd5};
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL restart_on_tick got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      step(1);
      stop = 1'b1;
      step(1);
      stop = 1'b0;
      exp = {1'b0, 1'b0, 1'b0, 16'd4};
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL restart_then_stop got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
   endtask

   task automatic test_edge_cases();
      logic [18:0] exp;
      int          n;
      // Zero load value is ignored in IDLE.
      load_val = 16'd0; start = 1'b1;
      step(1);
      start = 1'b0;
      exp = {1'b0, 1'b0, 1'b0, 16'd4};
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL zero_load_idle got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      // Zero load value is ignored in RUN.
      do_start(16'd3, 8'd1, 1'b0);
      step(2);
      load_val = 16'd0; start = 1'b1;
      step(1);
      start = 1'b0;
      exp = {1'b1, 1'b0, 1'b0, 16'd2};
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL zero_load_run got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      step(3);
      exp = {1'b0, 1'b1, 1'b1, 16'd0};
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL zero_load_run_expiry got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      // Zero load value is ignored in DONE.
      load_val = 16'd0; start = 1'b1;
      step(1);
      start = 1'b0;
      exp = {1'b0, 1'b0, 1'b1, 16'd0};
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL zero_load_done got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      irq_ack = 1'b1;
      step(1);
      irq_ack = 1'b0;
      // Acknowledge on the expiry edge: set wins.
      do_start(16'd1, 8'd0, 1'b0);
      irq_ack = 1'b1;
      step(1);
      irq_ack = 1'b0;
      exp = {1'b0, 1'b1, 1'b1, 16'd0};
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL ack_vs_expiry got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      irq_ack = 1'b1;
      step(1);
      irq_ack = 1'b0;
      exp = 19'h0;
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL ack_after got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      // Maximum load value, no prescaling.
      do_start(16'hFFFF, 8'd0, 1'b0);
      n = 0;
      while (expired !== 1'b1 && n < 70000) begin
         step(1);
         n++;
      end
      checks++;
      if (n != 65535) begin
         errors++;
         $display("FAIL max_load_latency got=%0d exp=%0d", n, 65535);
      end
      exp = {1'b0, 1'b1, 1'b1, 16'd0};
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL max_load_state got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      irq_ack = 1'b1;
      step(1);
      irq_ack = 1'b0;
   endtask

`ifdef TIMER_PAUSE_EN
   task automatic test_pause();
      logic [18:0] exp;
      do_start(16'd4, 8'd1, 1'b0);
      step(3);
      pause = 1'b1;
      step(5);
      pause = 1'b0;
      exp = {1'b1, 1'b0, 1'b0, 16'd3};
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL pause_frozen got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      step(4);
      exp = {1'b1, 1'b0, 1'b0, 16'd1};
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL pause_resume got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      step(1);
      exp = {1'b0, 1'b1, 1'b1, 16'd0};
      checks++;
      if ({busy, expired, irq, count} !== exp) begin
         errors++;
         $display("FAIL pause_delayed_expiry got=%h exp=%h", {busy, expired, irq, count}, exp);
      end
      irq_ack = 1'b1;
      step(1);
      irq_ack = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_oneshot();
      test_periodic();
      test_stop_restart();
      test_edge_cases();
`ifdef TIMER_PAUSE_EN
      test_pause();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule : tb_countdown_timer
